multibyte_add_sequencer: RTL and testbench



---
 rtl/add_seq_pkg.sv | 8 +
 rtl/multibyte_add_sequencer.sv | 95 +++++++++
 tb/tb_multibyte_add_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/multibyte_add_sequencer.sv
// Feeds an external 8-bit combinational adder one byte per clock, LSB byte
// first, chaining carries, and presents the NBYTES-wide sum over valid/ready.
module multibyte_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NBYTES*BYTE_W-1:0]   op_a,
  input  logic [NBYTES*BYTE_W-1:0]   op_b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NBYTES*BYTE_W-1:0]   result,
  output logic                       cout,
  output logic [BYTE_W-1:0]          add_a,
  output logic [BYTE_W-1:0]          add_b,
  output logic                       add_c,
  input  logic [BYTE_W-1:0]          add_sum,
  input  logic                       add_carry
);

  localparam int W    = NBYTES * BYTE_W;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  seq_state_e        state;
  logic [W-1:0]      a_sh;
  logic [W-1:0]      b_sh;
  logic [W-1:0]      res_sh;
  logic [W-1:0]      res_next;
  logic              carry_reg;
  logic [IDXW-1:0]   idx;
  logic              last_byte;

  // Adder sum bytes enter at the top so the final byte lands in the MSB slot.
  assign res_next  = (res_sh >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
  assign last_byte = (idx == IDXW'(NBYTES - 1));

  assign in_ready = (state == IDLE);
  assign add_a    = (state == RUN) ? a_sh[BYTE_W-1:0] : '0;
  assign add_b    = (state == RUN) ? b_sh[BYTE_W-1:0] : '0;
  assign add_c    = (state == RUN) ? carry_reg : 1'b0;

  // result/cout are separate from the working shift register so they stay
  // stable from one completion until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh      <= op_a;
            b_sh      <= op_b;
            carry_reg <= cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_sh      <= a_sh >> BYTE_W;
          b_sh      <= b_sh >> BYTE_W;
          res_sh    <= res_next;
          carry_reg <= add_carry;
          idx       <= idx + 1'b1;
          if (last_byte) begin
            result    <= res_next;
            cout      <= add_carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench: a 4-byte and a 1-byte sequencer, each closed around a
// behavioural 8-bit adder, checked against plain-arithmetic expectations.
module tb_multibyte_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cin = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        in_ready4, out_valid4, cout4, add_c4, add_carry4;
  logic [31:0] result4;
  logic [7:0]  add_a4, add_b4, add_sum4;

  logic        in_ready1, out_valid1, cout1, add_c1, add_carry1;
  logic [7:0]  result1;
  logic [7:0]  add_a1, add_b1, add_sum1;

  always #5 clk = ~clk;

  // The external 8-bit ripple adder, modelled behaviourally.
  assign {add_carry4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'b0, add_c4};
  assign {add_carry1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'b0, add_c1};

  multibyte_add_sequencer #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel), .in_ready(in_ready4),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .out_valid(out_valid4), .out_ready(out_ready & ~sel),
    .result(result4), .cout(cout4),
    .add_a(add_a4), .add_b(add_b4), .add_c(add_c4),
    .add_sum(add_sum4), .add_carry(add_carry4)
  );

  multibyte_add_sequencer #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel), .in_ready(in_ready1),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .cin(cin),
    .out_valid(out_valid1), .out_ready(out_ready & sel),
    .result(result1), .cout(cout1),
    .add_a(add_a1), .add_b(add_b1), .add_c(add_c1),
    .add_sum(add_sum1), .add_carry(add_carry1)
  );

  logic        obs_in_ready, obs_out_valid, obs_cout, obs_add_c;
  logic [31:0] obs_result;
  logic [7:0]  obs_add_a, obs_add_b;

  assign obs_in_ready  = sel ? in_ready1  : in_ready4;
  assign obs_out_valid = sel ? out_valid1 : out_valid4;
  assign obs_cout      = sel ? cout1      : cout4;
  assign obs_add_c     = sel ? add_c1     : add_c4;
  assign obs_add_a     = sel ? add_a1     : add_a4;
  assign obs_add_b     = sel ? add_b1     : add_b4;
  assign obs_result    = sel ? {24'b0, result1} : result4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operand pair and returns once the accepting edge has passed.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input logic c);
    int n;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    n = 0;
    while (!obs_in_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (obs_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", obs_in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (obs_out_valid) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({obs_in_ready, obs_out_valid, obs_cout} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags: in_ready/out_valid/cout=%b required 100",
               {obs_in_ready, obs_out_valid, obs_cout});
    end
    checks++;
    if (obs_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h required 00000000", obs_result);
    end
    checks++;
    if ({obs_add_a, obs_add_b, obs_add_c} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_adder_drive: a=%h b=%h c=%b required zeros",
               obs_add_a, obs_add_b, obs_add_c);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc;
    sel = 1'b0;
    do_accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("[TB] FAIL ripple_latency: got %0d cycles required 4", cyc);
    end
    checks++;
    if ({obs_cout, obs_result} !== {1'b0, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL ripple_result: got %b_%h required 0_00000100", obs_cout, obs_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_cin_chain();
    int cyc;
    sel = 1'b0;
    do_accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_add_c !== 1'b1) begin
        errors++;
        $display("[TB] FAIL cin_chain_add_c[%0d]: got %b required 1", i, obs_add_c);
      end
      if (i < 3) step();
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("[TB] FAIL cin_chain_latency: got %0d more cycles required 1", cyc);
    end
    checks++;
    if ({obs_cout, obs_result} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL cin_chain_result: got %b_%h required 1_00000000", obs_cout, obs_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    sel = 1'b0;
    do_accept(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(cyc);
    op_a = 32'h0000_0005; op_b = 32'h0000_0003; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({obs_out_valid, obs_in_ready, obs_cout, obs_result} !== {3'b100, 32'h2345_6789}) begin
        errors++;
        $display("[TB] FAIL hold_%0d: valid/ready/cout=%b result=%h required 100 23456789",
                 i, {obs_out_valid, obs_in_ready, obs_cout}, obs_result);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({obs_out_valid, obs_in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL release: valid/ready=%b required 01", {obs_out_valid, obs_in_ready});
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (obs_in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL second_accept: in_ready=%b required 0", obs_in_ready);
    end
    wait_done(cyc);
    checks++;
    if ({cyc, obs_cout, obs_result} !== {32'd4, 1'b0, 32'h0000_0008}) begin
      errors++;
      $display("[TB] FAIL second_result: cycles=%0d got %b_%h required 4 0_00000008",
               cyc, obs_cout, obs_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int cyc;
    sel = 1'b0;
    do_accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs_out_valid, obs_in_ready, obs_result} !== {2'b01, 32'h0}) begin
      errors++;
      $display("[TB] FAIL abort_state: valid/ready=%b result=%h required 01 00000000",
               {obs_out_valid, obs_in_ready}, obs_result);
    end
    #2;
    rst_n = 1'b1;
    step();
    do_accept(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    checks++;
    if ({cyc, obs_cout, obs_result} !== {32'd4, 1'b0, 32'h0000_0002}) begin
      errors++;
      $display("[TB] FAIL after_abort: cycles=%0d got %b_%h required 4 0_00000002",
               cyc, obs_cout, obs_result);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_random(input logic which, input int count);
    int          cyc, nbytes;
    logic [31:0] a, b;
    logic        c;
    longint      total, mask, exp_res;
    logic        exp_cout;
    sel = which;
    nbytes = which ? 1 : 4;
    mask = (longint'(1) << (8 * nbytes)) - 1;
    step();
    for (int n = 0; n < count; n++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      total = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
      exp_res  = total & mask;
      exp_cout = total[8 * nbytes];
      repeat ($urandom_range(0, 1)) step();
      do_accept(a, b, c);
      wait_done(cyc);
      checks++;
      if (cyc !== nbytes || {obs_cout, obs_result} !== {exp_cout, 32'(exp_res)}) begin
        errors++;
        $display("[TB] FAIL random_n%0d_%0d: cycles=%0d got %b_%h required %0d cycles %b_%h",
                 nbytes, n, cyc, obs_cout, obs_result, nbytes, exp_cout, 32'(exp_res));
      end
      repeat ($urandom_range(0, 3)) step();
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_cin_chain();
    test_backpressure();
    test_reset_abort();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
